uart_rx_buffer: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver.
- Captures each byte the receiver reports through Rx_DATA, Rx_VALID, Rx_FERROR and Rx_PERROR, and drops bytes flagged with framing or parity errors.
- Stores good bytes in a first-word-fall-through circular FIFO.
- Presents them to a consumer (display driver or checker logic) through a simple pop interface.

---
 rtl/uart_rx_buffer.sv | 126 ++++++++++++
 tb/tb_uart_rx_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// Receive-side FWFT byte FIFO behind the UART receiver: captures good bytes on Rx_VALID rising edges and drops errored ones.
// Optional per-error drop counters are enabled by defining UART_RX_BUFFER_ERR_COUNT_EN.
module uart_rx_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        Rx_DATA,
    input  logic              Rx_VALID,
    input  logic              Rx_FERROR,
    input  logic              Rx_PERROR,
    input  logic              rd_en,
    input  logic              clr_flags,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
`ifdef UART_RX_BUFFER_ERR_COUNT_EN
    output logic [7:0]        ferr_count,
    output logic [7:0]        perr_count,
`endif
    output logic              err_drop
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_reg [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              empty_reg, full_reg;
    logic              overflow_reg, err_drop_reg;
    logic              rx_valid_reg;

    logic capture, err_evt, push_cand, push, pop, ovf_evt;

    // One capture per Rx_VALID rising edge, no matter how long the level is held.
    assign capture   = Rx_VALID & ~rx_valid_reg;
    assign err_evt   = capture & (Rx_FERROR | Rx_PERROR);
    assign push_cand = capture & ~(Rx_FERROR | Rx_PERROR);
    assign pop       = rd_en & ~empty_reg;
    assign push      = push_cand & (~full_reg | pop);
    assign ovf_evt   = push_cand & full_reg & ~pop;

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            err_drop_reg <= 1'b0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= Rx_VALID;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg    <= count_next;
            empty_reg    <= (count_next == '0);
            full_reg     <= (count_next == FULL_COUNT);
            // Setting event wins over a simultaneous clear.
            overflow_reg <= (overflow_reg & ~clr_flags) | ovf_evt;
            err_drop_reg <= (err_drop_reg & ~clr_flags) | err_evt;
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= Rx_DATA;
        end
    end

    assign rd_data  = empty_reg ? 8'h00 : mem_reg[rd_ptr_reg];
    assign empty    = empty_reg;
    assign full     = full_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign err_drop = err_drop_reg;

`ifdef UART_RX_BUFFER_ERR_COUNT_EN
    logic [7:0] ferr_count_reg, ferr_count_next;
    logic [7:0] perr_count_reg, perr_count_next;

    // Clear first, then a same-cycle increment lands on the cleared value; saturate at 255.
    always_comb begin
        ferr_count_next = clr_flags ? 8'h00 : ferr_count_reg;
        perr_count_next = clr_flags ? 8'h00 : perr_count_reg;
        if (err_evt && Rx_FERROR && ferr_count_next != 8'hFF) begin
            ferr_count_next = ferr_count_next + 1'b1;
        end
        if (err_evt && Rx_PERROR && perr_count_next != 8'hFF) begin
            perr_count_next = perr_count_next + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_count_reg <= 8'h00;
            perr_count_reg <= 8'h00;
        end else begin
            ferr_count_reg <= ferr_count_next;
            perr_count_reg <= perr_count_next;
        end
    end

    assign ferr_count = ferr_count_reg;
    assign perr_count = perr_count_reg;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: a vector table for capture/error behaviour plus
// hand-written sequences for fill, overflow, wrap, simultaneous push/pop and mid-run reset.
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_FERROR, Rx_PERROR, rd_en, clr_flags;
    logic [7:0] rd_data;
    logic       empty, full, overflow, err_drop;
    logic [4:0] count;
`ifdef UART_RX_BUFFER_ERR_COUNT_EN
    logic [7:0] ferr_count, perr_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_rx_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Rx_DATA   (Rx_DATA),
        .Rx_VALID  (Rx_VALID),
        .Rx_FERROR (Rx_FERROR),
        .Rx_PERROR (Rx_PERROR),
        .rd_en     (rd_en),
        .clr_flags (clr_flags),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
`ifdef UART_RX_BUFFER_ERR_COUNT_EN
        .ferr_count(ferr_count),
        .perr_count(perr_count),
`endif
        .err_drop  (err_drop)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       fe, pe, rd, clr;
        int         cnt;
        logic       emp, ful;
        logic [7:0] rdd;
        logic       ovf, erd;
        int         fc, pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic fe, input logic pe,
                       input logic rd, input logic clr, input int cnt, input logic emp,
                       input logic ful, input logic [7:0] rdd, input logic ovf, input logic erd,
                       input int fc, input int pc);
        vec_t t;
        t.v = v; t.d = d; t.fe = fe; t.pe = pe; t.rd = rd; t.clr = clr;
        t.cnt = cnt; t.emp = emp; t.ful = ful; t.rdd = rdd; t.ovf = ovf; t.erd = erd;
        t.fc = fc; t.pc = pc;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic fe, input logic pe,
                        input logic rd, input logic clr);
        Rx_VALID = v; Rx_DATA = d; Rx_FERROR = fe; Rx_PERROR = pe; rd_en = rd; clr_flags = clr;
        @(posedge clk);
        #1;
        $display("[TB] t=%0t rst=%0b v=%0b d=%02h fe=%0b pe=%0b rd=%0b clr=%0b -> cnt=%0d empty=%0b full=%0b rdata=%02h ovf=%0b errd=%0b",
                 $time, reset, v, d, fe, pe, rd, clr, count, empty, full, rd_data, overflow, err_drop);
    endtask

    task automatic push_byte(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        Rx_VALID = 1'b0; Rx_DATA = 8'h00; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
        rd_en = 1'b0; clr_flags = 1'b0;

        // v  data  fe pe rd clr | cnt emp ful rdata ovf errd fc pc
        add(0, 8'h00, 0, 0, 0, 0,  0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'hA5, 0, 0, 0, 0,  1, 0, 0, 8'hA5, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0,  0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0,  0, 1, 0, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 8'h3C, 0, 0, 0, 0, 1, 0, 0, 8'h3C, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0,  0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h55, 0, 1, 0, 0,  0, 1, 0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0,  0, 1, 0, 8'h00, 0, 1, 0, 1);
        add(1, 8'h66, 1, 0, 0, 0,  0, 1, 0, 8'h00, 0, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 1,  0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h77, 1, 1, 0, 0,  0, 1, 0, 8'h00, 0, 1, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0,  0, 1, 0, 8'h00, 0, 1, 1, 1);
        add(1, 8'h88, 1, 0, 0, 1,  0, 1, 0, 8'h00, 0, 1, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1,  0, 1, 0, 8'h00, 0, 0, 0, 0);

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'h00);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d, vecs[i].fe, vecs[i].pe, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ful));
            chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rdd));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_err_drop", i), 32'(err_drop), 32'(vecs[i].erd));
`ifdef UART_RX_BUFFER_ERR_COUNT_EN
            chk($sformatf("vec%0d_ferr_count", i), 32'(ferr_count), 32'(vecs[i].fc));
            chk($sformatf("vec%0d_perr_count", i), 32'(perr_count), 32'(vecs[i].pc));
`endif
        end

        // Fill, overflow, drain in order, then wrap.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_head", 32'(rd_data), 32'h00);
        chk("fill_no_ovf", 32'(overflow), 32'd0);
        push_byte(8'h10);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_data", i), 32'(rd_data), 32'(i));
            pop_one();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        push_byte(8'h20);
        chk("wrap_rd_data", 32'(rd_data), 32'h20);
        chk("wrap_count", 32'(count), 32'd1);

        // Full FIFO: push and pop in the same cycle keeps count and stores the new tail.
        for (int i = 1; i < 16; i++) push_byte(8'(8'h20 + i));
        chk("refill_full", 32'(full), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("simul_full_count", 32'(count), 32'd16);
        chk("simul_full_ovf", 32'(overflow), 32'd0);
        chk("simul_full_head", 32'(rd_data), 32'h21);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain2_%0d_data", i), 32'(rd_data), (i < 15) ? 32'(8'h21 + i) : 32'h77);
            pop_one();
        end
        chk("drain2_empty", 32'(empty), 32'd1);

        // Empty FIFO: the pop is ignored, the push lands.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("simul_empty_count", 32'(count), 32'd1);
        chk("simul_empty_rd_data", 32'(rd_data), 32'h11);
        chk("simul_empty_empty", 32'(empty), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reach 5 entries with overflow set, then reset mid-operation.
        for (int i = 0; i < 15; i++) push_byte(8'(8'h40 + i));
        chk("pre_rst_full", 32'(full), 32'd1);
        push_byte(8'h50);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 11; i++) pop_one();
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_head", 32'(rd_data), 32'h4A);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        push_byte(8'h99);
        chk("post_rst_rd_data", 32'(rd_data), 32'h99);
        chk("post_rst_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
